// File: rtl/double_buffer_ctrl.sv
// double_buffer_ctrl: ping-pong AXI write arbiter for two blocking buffers with mid-burst handoff and drain ordering
//   clk_i/rst_i          : clock, asynchronous active-high reset
//   s_axi_*              : upstream AW/W/B handshakes, muxed to the active buffer
//   buf_*_i / buf_*_o    : per-buffer handshakes, availability, continue pulses, captured burst attributes
//   rd_valid_o/rd_sel_o  : oldest filled buffer, so the consumer drains in write order
//   handoff_cnt_o/stall_cnt_o/error_o : saturating statistics and sticky protocol error
module double_buffer_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_axi_awvalid_i,
    input  logic        s_axi_wvalid_i,
    output logic        s_axi_awready_o,
    output logic        s_axi_wready_o,
    output logic        s_axi_bvalid_o,
    input  logic [1:0]  buf_awready_i,
    input  logic [1:0]  buf_wready_i,
    input  logic [1:0]  buf_bvalid_i,
    output logic [1:0]  buf_wvalid_o,
    input  logic [1:0]  buf_available_i,
    input  logic [1:0]  buf_continue_i,
    input  logic [5:0]  buf_aw_size_i,
    input  logic [3:0]  buf_aw_burst_i,
    output logic [1:0]  buf_grant_o,
    output logic [1:0]  buf_continue_o,
    output logic [2:0]  buf_aw_size_o,
    output logic [1:0]  buf_aw_burst_o,
    output logic        rd_valid_o,
    output logic        rd_sel_o,
    output logic [15:0] handoff_cnt_o,
    output logic [15:0] stall_cnt_o,
    output logic        error_o
);
    localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, HANDOFF = 2'd2;
    logic [1:0]  state_q, state_d;
    logic        active_q, active_d, target_q, target_d;
    logic [2:0]  cap_size_q, cap_size_d;
    logic [1:0]  cap_burst_q, cap_burst_d;
    logic [15:0] handoff_cnt_q, handoff_cnt_d, stall_cnt_q, stall_cnt_d;
    logic        error_q, error_d;
    logic [1:0]  avail_q, avail_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d, tail_q, tail_d;
    logic [1:0]  fall, rise;
    logic        run, pop, ovf, unf;
    // Stalls are counted for every WAIT cycle regardless of AW activity, so awvalid is not needed.
    logic        unused_awvalid;
    assign unused_awvalid = s_axi_awvalid_i;
    assign run             = state_q == RUN;
    assign buf_grant_o     = run ? (active_q ? 2'b10 : 2'b01) : 2'b00;
    assign s_axi_awready_o = run & buf_awready_i[active_q];
    assign s_axi_wready_o  = run & buf_wready_i[active_q];
    assign buf_wvalid_o    = s_axi_wvalid_i ? buf_grant_o : 2'b00;
    assign s_axi_bvalid_o  = |buf_bvalid_i;
    assign buf_continue_o  = state_q == HANDOFF ? (target_q ? 2'b10 : 2'b01) : 2'b00;
    assign buf_aw_size_o   = cap_size_q;
    assign buf_aw_burst_o  = cap_burst_q;
    assign rd_valid_o      = cnt_q != 2'd0;
    assign rd_sel_o        = rd_valid_o & head_q;
    assign handoff_cnt_o   = handoff_cnt_q;
    assign stall_cnt_o     = stall_cnt_q;
    assign error_o         = error_q;
    assign fall = avail_q & ~buf_available_i;
    assign rise = ~avail_q & buf_available_i;
    assign pop  = rd_valid_o & rise[head_q];
    assign unf  = (|rise) & ~rd_valid_o;
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        target_d      = target_q;
        cap_size_d    = cap_size_q;
        cap_burst_d   = cap_burst_q;
        handoff_cnt_d = handoff_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (state_q == RUN && buf_continue_i[active_q]) begin
            cap_size_d  = active_q ? buf_aw_size_i[5:3] : buf_aw_size_i[2:0];
            cap_burst_d = active_q ? buf_aw_burst_i[3:2] : buf_aw_burst_i[1:0];
            target_d    = ~active_q;
            state_d     = buf_available_i[~active_q] ? HANDOFF : WAIT;
        end else if (state_q == WAIT) begin
            stall_cnt_d = stall_cnt_q + 16'(stall_cnt_q != 16'hFFFF);
            state_d     = buf_available_i[target_q] ? HANDOFF : WAIT;
        end else if (state_q == HANDOFF) begin
            active_d      = target_q;
            handoff_cnt_d = handoff_cnt_q + 16'(handoff_cnt_q != 16'hFFFF);
            state_d       = RUN;
        end
    end
    // Pop is applied before pushes; simultaneous falls enqueue buffer 0 ahead of buffer 1.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        ovf    = 1'b0;
        if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end
        for (int i = 0; i < 2; i++) begin
            if (fall[i]) begin
                if (cnt_d == 2'd2) begin
                    ovf = 1'b1;
                end else begin
                    if (cnt_d == 2'd0) head_d = 1'(i);
                    else tail_d = 1'(i);
                    cnt_d = cnt_d + 2'd1;
                end
            end
        end
    end
    assign avail_d = buf_available_i;
    assign error_d = error_q | buf_continue_i[~active_q] | (buf_continue_i[active_q] & ~run) | ovf | unf;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            active_q      <= 1'b0;
            target_q      <= 1'b0;
            cap_size_q    <= 3'd0;
            cap_burst_q   <= 2'd0;
            handoff_cnt_q <= 16'd0;
            stall_cnt_q   <= 16'd0;
            error_q       <= 1'b0;
            avail_q       <= 2'b11;
            cnt_q         <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            target_q      <= target_d;
            cap_size_q    <= cap_size_d;
            cap_burst_q   <= cap_burst_d;
            handoff_cnt_q <= handoff_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            error_q       <= error_d;
            avail_q       <= avail_d;
            cnt_q         <= cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end
endmodule

// File: tb/tb_double_buffer_ctrl.sv
// tb_double_buffer_ctrl: directed scenario tests for double_buffer_ctrl
module tb_double_buffer_ctrl;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        s_axi_awvalid_i = 1'b0, s_axi_wvalid_i = 1'b0;
    logic        s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o;
    logic [1:0]  buf_awready_i = 2'b11, buf_wready_i = 2'b11, buf_bvalid_i = 2'b00;
    logic [1:0]  buf_wvalid_o;
    logic [1:0]  buf_available_i = 2'b11, buf_continue_i = 2'b00;
    logic [5:0]  buf_aw_size_i = 6'd0;
    logic [3:0]  buf_aw_burst_i = 4'd0;
    logic [1:0]  buf_grant_o, buf_continue_o, buf_aw_burst_o;
    logic [2:0]  buf_aw_size_o;
    logic        rd_valid_o, rd_sel_o, error_o;
    logic [15:0] handoff_cnt_o, stall_cnt_o;
    int compared = 0, mismatched = 0;

    double_buffer_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_wvalid_i(s_axi_wvalid_i),
        .s_axi_awready_o(s_axi_awready_o), .s_axi_wready_o(s_axi_wready_o), .s_axi_bvalid_o(s_axi_bvalid_o),
        .buf_awready_i(buf_awready_i), .buf_wready_i(buf_wready_i), .buf_bvalid_i(buf_bvalid_i),
        .buf_wvalid_o(buf_wvalid_o), .buf_available_i(buf_available_i), .buf_continue_i(buf_continue_i),
        .buf_aw_size_i(buf_aw_size_i), .buf_aw_burst_i(buf_aw_burst_i),
        .buf_grant_o(buf_grant_o), .buf_continue_o(buf_continue_o),
        .buf_aw_size_o(buf_aw_size_o), .buf_aw_burst_o(buf_aw_burst_o),
        .rd_valid_o(rd_valid_o), .rd_sel_o(rd_sel_o),
        .handoff_cnt_o(handoff_cnt_o), .stall_cnt_o(stall_cnt_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3 rst_i = 1'b1;
        #1;
        compared++;
        if ({buf_grant_o, buf_continue_o, buf_aw_size_o, buf_aw_burst_o, rd_valid_o, rd_sel_o, error_o} !== {2'b01, 2'b00, 3'd0, 2'd0, 3'b000}) begin
            mismatched++;
            $display("FAIL reset_outs: got grant=%b cont=%b size=%0d burst=%0d rdv=%b rds=%b err=%b", buf_grant_o, buf_continue_o, buf_aw_size_o, buf_aw_burst_o, rd_valid_o, rd_sel_o, error_o);
        end
        compared++;
        if ({handoff_cnt_o, stall_cnt_o} !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_cnts: got handoff=%0d stall=%0d expected 0 0", handoff_cnt_o, stall_cnt_o);
        end
        buf_awready_i = 2'b01;
        #1;
        compared++;
        if (s_axi_awready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_awready0: got %b expected 1", s_axi_awready_o);
        end
        buf_awready_i = 2'b10;
        #1;
        compared++;
        if (s_axi_awready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_awready1: got %b expected 0", s_axi_awready_o);
        end
        buf_awready_i = 2'b11;
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_normal_handoff();
        buf_continue_i = 2'b01;
        buf_aw_size_i  = 6'b000_011;
        buf_aw_burst_i = 4'b00_01;
        s_axi_wvalid_i = 1'b1;
        #1;
        compared++;
        if ({s_axi_wready_o, buf_wvalid_o} !== 3'b1_01) begin
            mismatched++;
            $display("FAIL normal_old_beat: got wready=%b wvalid=%b expected 1 01", s_axi_wready_o, buf_wvalid_o);
        end
        step();
        buf_continue_i = 2'b00;
        #1;
        compared++;
        if ({buf_grant_o, buf_continue_o, buf_aw_size_o, buf_aw_burst_o, s_axi_wready_o, buf_wvalid_o} !== {2'b00, 2'b10, 3'd3, 2'd1, 1'b0, 2'b00}) begin
            mismatched++;
            $display("FAIL normal_handoff: got grant=%b cont=%b size=%0d burst=%0d wready=%b wvalid=%b", buf_grant_o, buf_continue_o, buf_aw_size_o, buf_aw_burst_o, s_axi_wready_o, buf_wvalid_o);
        end
        step();
        buf_wready_i = 2'b01;
        #1;
        compared++;
        if ({buf_grant_o, handoff_cnt_o, s_axi_wready_o, buf_wvalid_o, buf_continue_o} !== {2'b10, 16'd1, 1'b0, 2'b10, 2'b00}) begin
            mismatched++;
            $display("FAIL normal_after: got grant=%b handoff=%0d wready=%b wvalid=%b cont=%b", buf_grant_o, handoff_cnt_o, s_axi_wready_o, buf_wvalid_o, buf_continue_o);
        end
        buf_wready_i = 2'b11;
        s_axi_wvalid_i = 1'b0;
    endtask

    task automatic test_stalled_handoff();
        buf_continue_i  = 2'b10;
        buf_available_i = 2'b10;
        buf_aw_size_i   = 6'b101_010;
        buf_aw_burst_i  = 4'b10_00;
        step();
        buf_continue_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if ({s_axi_wready_o, s_axi_awready_o, buf_grant_o, buf_continue_o} !== 6'b0) begin
                mismatched++;
                $display("FAIL stall_wait%0d: got wready=%b awready=%b grant=%b cont=%b", i, s_axi_wready_o, s_axi_awready_o, buf_grant_o, buf_continue_o);
            end
            if (i == 0) begin
                compared++;
                if ({rd_valid_o, rd_sel_o} !== 2'b10) begin
                    mismatched++;
                    $display("FAIL stall_fifo_push: got rdv=%b rds=%b expected 1 0", rd_valid_o, rd_sel_o);
                end
            end
            step();
        end
        buf_available_i = 2'b11;
        #1;
        compared++;
        if ({s_axi_wready_o, buf_continue_o} !== 3'b0) begin
            mismatched++;
            $display("FAIL stall_last_wait: got wready=%b cont=%b expected 0 00", s_axi_wready_o, buf_continue_o);
        end
        step();
        compared++;
        if ({buf_continue_o, buf_aw_size_o, buf_aw_burst_o, stall_cnt_o, s_axi_wready_o, rd_valid_o} !== {2'b01, 3'd5, 2'd2, 16'd5, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL stall_handoff: got cont=%b size=%0d burst=%0d stall=%0d wready=%b rdv=%b", buf_continue_o, buf_aw_size_o, buf_aw_burst_o, stall_cnt_o, s_axi_wready_o, rd_valid_o);
        end
        step();
        compared++;
        if ({buf_grant_o, handoff_cnt_o, s_axi_wready_o, stall_cnt_o} !== {2'b01, 16'd2, 1'b1, 16'd5}) begin
            mismatched++;
            $display("FAIL stall_after: got grant=%b handoff=%0d wready=%b stall=%0d", buf_grant_o, handoff_cnt_o, s_axi_wready_o, stall_cnt_o);
        end
    endtask

    task automatic test_drain_order();
        buf_available_i = 2'b01;
        #1;
        compared++;
        if (rd_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_lag: got rdv=%b expected 0", rd_valid_o);
        end
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b11) begin
            mismatched++;
            $display("FAIL drain_first: got rdv=%b rds=%b expected 1 1", rd_valid_o, rd_sel_o);
        end
        step();
        step();
        buf_available_i = 2'b00;
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b11) begin
            mismatched++;
            $display("FAIL drain_both: got rdv=%b rds=%b expected 1 1", rd_valid_o, rd_sel_o);
        end
        buf_available_i = 2'b10;
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b10) begin
            mismatched++;
            $display("FAIL drain_pop1: got rdv=%b rds=%b expected 1 0", rd_valid_o, rd_sel_o);
        end
        buf_available_i = 2'b11;
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b00) begin
            mismatched++;
            $display("FAIL drain_empty: got rdv=%b rds=%b expected 0 0", rd_valid_o, rd_sel_o);
        end
        buf_available_i = 2'b00;
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b10) begin
            mismatched++;
            $display("FAIL drain_simul: got rdv=%b rds=%b expected 1 0", rd_valid_o, rd_sel_o);
        end
        buf_available_i = 2'b01;
        step();
        compared++;
        if ({rd_valid_o, rd_sel_o} !== 2'b11) begin
            mismatched++;
            $display("FAIL drain_simul_pop0: got rdv=%b rds=%b expected 1 1", rd_valid_o, rd_sel_o);
        end
        buf_available_i = 2'b11;
        step();
        compared++;
        if ({rd_valid_o, error_o} !== 2'b00) begin
            mismatched++;
            $display("FAIL drain_simul_end: got rdv=%b err=%b expected 0 0", rd_valid_o, error_o);
        end
    endtask

    task automatic test_stray_continue();
        buf_continue_i = 2'b10;
        step();
        buf_continue_i = 2'b00;
        #1;
        compared++;
        if ({error_o, buf_grant_o, buf_continue_o} !== {1'b1, 2'b01, 2'b00}) begin
            mismatched++;
            $display("FAIL stray_set: got err=%b grant=%b cont=%b expected 1 01 00", error_o, buf_grant_o, buf_continue_o);
        end
        step();
        step();
        step();
        compared++;
        if ({error_o, buf_grant_o} !== 3'b1_01) begin
            mismatched++;
            $display("FAIL stray_sticky: got err=%b grant=%b expected 1 01", error_o, buf_grant_o);
        end
    endtask

    task automatic test_late_bvalid();
        buf_continue_i = 2'b01;
        step();
        buf_continue_i = 2'b00;
        step();
        buf_bvalid_i = 2'b01;
        #1;
        compared++;
        if ({s_axi_bvalid_o, buf_grant_o, handoff_cnt_o} !== {1'b1, 2'b10, 16'd3}) begin
            mismatched++;
            $display("FAIL late_bvalid: got bvalid=%b grant=%b handoff=%0d expected 1 10 3", s_axi_bvalid_o, buf_grant_o, handoff_cnt_o);
        end
        buf_bvalid_i = 2'b00;
        #1;
        compared++;
        if (s_axi_bvalid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL bvalid_idle: got %b expected 0", s_axi_bvalid_o);
        end
    endtask

    task automatic test_reset_in_wait();
        buf_continue_i  = 2'b10;
        buf_available_i = 2'b10;
        step();
        buf_continue_i = 2'b00;
        step();
        compared++;
        if ({buf_grant_o, s_axi_wready_o} !== 3'b000) begin
            mismatched++;
            $display("FAIL wait_entry: got grant=%b wready=%b expected 00 0", buf_grant_o, s_axi_wready_o);
        end
        #3 rst_i = 1'b1;
        #1;
        compared++;
        if ({buf_grant_o, buf_continue_o, error_o, rd_valid_o, stall_cnt_o, handoff_cnt_o} !== {2'b01, 2'b00, 2'b00, 32'd0}) begin
            mismatched++;
            $display("FAIL wait_reset: got grant=%b cont=%b err=%b rdv=%b stall=%0d handoff=%0d", buf_grant_o, buf_continue_o, error_o, rd_valid_o, stall_cnt_o, handoff_cnt_o);
        end
        buf_available_i = 2'b11;
        step();
        rst_i = 1'b0;
        step();
        step();
        compared++;
        if ({buf_grant_o, buf_continue_o, stall_cnt_o} !== {2'b01, 2'b00, 16'd0}) begin
            mismatched++;
            $display("FAIL wait_dropped: got grant=%b cont=%b stall=%0d expected 01 00 0", buf_grant_o, buf_continue_o, stall_cnt_o);
        end
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_normal_handoff();
        test_stalled_handoff();
        test_drain_order();
        test_stray_continue();
        test_late_bvalid();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
